// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM encoding and BCD helper for the seven-segment scan path.
package seven_seg_pkg;

    localparam int           NUM_DIGITS = 4;
    localparam int           SCORE_MAX  = 9999;
    localparam logic [3:0]   AN_OFF     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Sequential double-dabble converter: one bit per cycle, SCORE_W cycles, input
// saturated to SCORE_MAX on capture. busy spans CONV and DONE; done pulses in DONE.
module bin2bcd_serial
    import seven_seg_pkg::*;
#(
    parameter int SCORE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic [15:0]        bcd,
    output logic               done
);

    localparam int EW = (SCORE_W > 14) ? SCORE_W : 14;
    localparam int CW = $clog2(SCORE_W + 1);

    conv_state_e        state, state_nxt;
    logic [SCORE_W-1:0] sh;
    logic [15:0]        acc;
    logic [CW-1:0]      cnt;

    logic [EW-1:0]      bin_ext, sat_ext;
    logic [SCORE_W-1:0] sat;

    // Clamp in a width that can always hold SCORE_MAX, then narrow back.
    always_comb begin
        bin_ext = EW'(bin);
        sat_ext = (bin_ext > EW'(SCORE_MAX)) ? EW'(SCORE_MAX) : bin_ext;
        sat     = sat_ext[SCORE_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CONV;
            CONV: if (cnt == CW'(SCORE_W - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    sh  <= sat;
                    acc <= '0;
                    cnt <= '0;
                end
                CONV: begin
                    {acc, sh} <= {bcd_adjust(acc), sh} << 1;
                    cnt       <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = acc;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scanner fed by a serial binary-to-BCD converter.
// Optional leading-zero blanking via `SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SCORE_W     = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] value,
    input  logic               load,
    output logic               busy,
    output logic [3:0]         digit,
    output logic [3:0]         an
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [15:0]                 bcd;
    logic                        done;
    logic [PW-1:0]               psc;
    logic [1:0]                  idx;
    logic [NUM_DIGITS-1:0][3:0]  disp;
    logic [3:0]                  an_scan;
    logic [NUM_DIGITS-1:0]       blank;

    bin2bcd_serial #(.SCORE_W(SCORE_W)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (value),
        .busy  (busy),
        .bcd   (bcd),
        .done  (done)
    );

    // Prescaler and scan index free-run regardless of conversion activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
            idx <= '0;
        end else if (psc == PW'(REFRESH_DIV - 1)) begin
            psc <= '0;
            idx <= idx + 2'd1;
        end else begin
            psc <= psc + PW'(1);
        end
    end

    // Display holds the previous value until the converter commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            disp <= '0;
        else if (done)
            disp <= bcd;
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    always_comb begin
        blank[3] = (disp[3] == 4'd0);
        blank[2] = blank[3] && (disp[2] == 4'd0);
        blank[1] = blank[2] && (disp[1] == 4'd0);
        blank[0] = 1'b0;
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        an_scan = ~(4'b0001 << idx);
        digit   = disp[idx];
        an      = blank[idx] ? AN_OFF : an_scan;
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl at REFRESH_DIV=4; blanking expectations
// follow `SEVEN_SEG_LZ_BLANK_EN.
module tb_seven_seg_scan_ctrl;

    localparam int RD = 4;
    localparam int SW = 14;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [SW-1:0] value = '0;
    logic          busy;
    logic [3:0]    digit;
    logic [3:0]    an;

    int n_chk  = 0;
    int n_fail = 0;

    seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .SCORE_W(SW)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .busy  (busy),
        .digit (digit),
        .an    (an)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [SW-1:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    function automatic int idx_of(input logic [3:0] a);
        for (int i = 0; i < 4; i++)
            if (!a[i]) return i;
        return 0;
    endfunction

    task automatic scan(output logic [15:0] d, output logic [3:0] m, output int multi);
        d = '0;
        m = '0;
        multi = 0;
        for (int c = 0; c < 4 * RD; c++) begin
            int lows;
            lows = 0;
            for (int i = 0; i < 4; i++) begin
                if (!an[i]) begin
                    lows++;
                    m[i] = 1'b1;
                    d[i*4 +: 4] = digit;
                end
            end
            if (lows > 1) multi++;
            tick();
        end
    endtask

    task automatic check_disp(input string tag, input logic [15:0] exp_d, input logic [3:0] lz_mask);
        logic [3:0]  em;
        logic [15:0] dm;
        logic [15:0] d;
        logic [3:0]  m;
        int          multi;
        em = LZ ? lz_mask : 4'hf;
        dm = '0;
        for (int i = 0; i < 4; i++)
            dm[i*4 +: 4] = em[i] ? 4'hf : 4'h0;
        scan(d, m, multi);
        chk({tag, " an mask"}, 32'(m), 32'(em));
        chk({tag, " digits"}, 32'(d & dm), 32'(exp_d & dm));
        chk({tag, " multi-low"}, 32'(multi), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst an", 32'(an), 32'he);
        chk("rst digit", 32'(digit), 32'd0);

        // Scan sequence after release
        @(posedge clk); #1;
        rst = 1'b0;
        chk("scan an k0", 32'(an), 32'he);
        repeat (RD) tick();
        chk("scan an k4", 32'(an), 32'hd);
        repeat (RD) tick();
        chk("scan an k8", 32'(an), 32'hb);
        repeat (RD) tick();
        chk("scan an k12", 32'(an), 32'h7);
        repeat (RD) tick();
        chk("scan an k16", 32'(an), 32'he);

        // Conversion of 1234
        do_load(14'd1234);
        chk("busy after load", 32'(busy), 32'd1);
        chk("old digit during busy", 32'(digit), 32'd0);
        wait_idle(n);
        chk("1234 busy cycles", 32'(n), 32'd15);
        chk("new digit at busy fall", 32'(digit), 32'(nib(16'h1234, idx_of(an))));
        check_disp("1234", 16'h1234, 4'hf);

        // Saturation; old value stays visible while converting
        do_load(14'd16383);
        tick(); tick();
        chk("sat old digit", 32'(digit), 32'(nib(16'h1234, idx_of(an))));
        wait_idle(n);
        chk("sat busy cycles", 32'(n), 32'd13);
        check_disp("sat", 16'h9999, 4'hf);

        // load while converting is ignored
        do_load(14'd1234);
        tick(); tick();
        value = 14'd5;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        wait_idle(n);
        chk("ignored load busy", 32'(n + 3), 32'd15);
        check_disp("ignored", 16'h1234, 4'hf);

        // load in the cycle busy falls is accepted
        do_load(14'd8);
        wait_idle(n);
        do_load(14'd42);
        chk("load at busy fall", 32'(busy), 32'd1);
        wait_idle(n);
        chk("42 busy cycles", 32'(n), 32'd15);
        check_disp("42", 16'h0042, 4'b0011);

        do_load(14'd0);
        wait_idle(n);
        check_disp("zero", 16'h0000, 4'b0001);

        // Abort mid-conversion
        do_load(14'd8888);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort an", 32'(an), 32'he);
        chk("abort digit", 32'(digit), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_disp("abort", 16'h0000, 4'b0001);
        do_load(14'd7);
        wait_idle(n);
        chk("7 busy cycles", 32'(n), 32'd15);
        check_disp("7", 16'h0007, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
